// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 responder emulating a minimal serial NOR flash over a byte-wide memory port
// Ports: clk, reset (async, active-high); spi_csb/spi_clk/spi_si in, spi_so out (SPI link, oversampled);
//   mem_addr/mem_rd/mem_rdata/mem_wr/mem_wdata external memory (rdata valid 1 clk after mem_rd);
//   active high while synced chip select is low.
// Commands: 0x03 read, 0x9F JEDEC ID, 0x05 status; with SPI_RESP_PROG_EN defined also
//   0x06 WREN, 0x04 WRDI, 0x02 page program. Without it the responder is read-only.
module spi_flash_responder #(
  parameter int          AW       = 16,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          spi_csb,
  input  logic          spi_clk,
  input  logic          spi_si,
  output logic          spi_so,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [7:0]    mem_rdata,
  output logic          mem_wr,
  output logic [7:0]    mem_wdata,
  output logic          active
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA_OUT, DATA_IN, IGNORE} state_t;
  typedef enum logic [1:0] {SRC_MEM, SRC_ID, SRC_STAT} src_t;
  state_t        state_q;
  src_t          src_q;
  logic [1:0]    csb_s, si_s;
  logic [2:0]    sck_s;
  logic [2:0]    bit_q;
  logic [6:0]    sh_q, out_q;
  logic [7:0]    pre_q, nb, nxt;
  logic [1:0]    cnt_q, id_q;
  logic [AW-1:0] addr_q;
  logic          rd_q, cap_q, so_q, wel;
  logic          csb, rise, fall, done;
`ifdef SPI_RESP_PROG_EN
  logic          wel_q, prog_q, pgm_q, wr_q;
  logic [7:0]    wdata_q;
  assign wel       = wel_q;
  assign mem_wr    = wr_q;
  assign mem_wdata = wdata_q;
`else
  assign wel       = 1'b0;
  assign mem_wr    = 1'b0;
  assign mem_wdata = 8'h00;
`endif
  assign csb      = csb_s[1];
  assign rise     = sck_s[1] & ~sck_s[2];
  assign fall     = ~sck_s[1] & sck_s[2];
  assign nb       = {sh_q, si_s[1]};
  assign done     = rise && bit_q == 3'd7;
  assign spi_so   = so_q;
  assign mem_addr = addr_q;
  assign mem_rd   = rd_q;
  assign active   = ~csb;
  // Byte presented to the master at the start of each DATA_OUT byte
  always_comb
    nxt = src_q == SRC_MEM ? pre_q :
          src_q == SRC_STAT ? {6'b0, wel, 1'b0} :
          id_q == 2'd0 ? JEDEC_ID[23:16] :
          id_q == 2'd1 ? JEDEC_ID[15:8] :
          id_q == 2'd2 ? JEDEC_ID[7:0] : 8'h00;
  // Chip select resets to inactive so active stays low through reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      csb_s <= 2'b11;
      sck_s <= '0;
      si_s  <= '0;
    end else begin
      csb_s <= {csb_s[0], spi_csb};
      sck_s <= {sck_s[1:0], spi_clk};
      si_s  <= {si_s[0], spi_si};
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      src_q   <= SRC_MEM;
      bit_q   <= '0;
      sh_q    <= '0;
      out_q   <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      cap_q   <= 1'b0;
      so_q    <= 1'b0;
`ifdef SPI_RESP_PROG_EN
      wel_q   <= 1'b0;
      prog_q  <= 1'b0;
      pgm_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
`endif
    end else begin
      rd_q  <= 1'b0;
      cap_q <= rd_q;
      if (cap_q) pre_q <= mem_rdata;
`ifdef SPI_RESP_PROG_EN
      wr_q <= 1'b0;
      // Page-wrapping increment once the write strobe has been presented
      if (wr_q) addr_q[7:0] <= addr_q[7:0] + 8'd1;
`endif
      if (csb) begin
        state_q <= IDLE;
        bit_q   <= '0;
        cnt_q   <= '0;
        id_q    <= '0;
        so_q    <= 1'b0;
        rd_q    <= 1'b0;
`ifdef SPI_RESP_PROG_EN
        wr_q  <= 1'b0;
        pgm_q <= 1'b0;
        if (pgm_q) wel_q <= 1'b0;
`endif
      end else begin
        if (rise && state_q != IDLE) begin
          sh_q  <= nb[6:0];
          bit_q <= bit_q + 3'd1;
        end
        case (state_q)
          IDLE: state_q <= CMD;
          CMD: if (done) begin
            state_q <= IGNORE;
            if (nb == 8'h03) begin
              state_q <= ADDR;
              src_q   <= SRC_MEM;
            end
            if (nb == 8'h9F) begin
              state_q <= DATA_OUT;
              src_q   <= SRC_ID;
            end
            if (nb == 8'h05) begin
              state_q <= DATA_OUT;
              src_q   <= SRC_STAT;
            end
`ifdef SPI_RESP_PROG_EN
            prog_q <= nb == 8'h02;
            if (nb == 8'h02) begin
              state_q <= ADDR;
              pgm_q   <= 1'b1;
            end
            if (nb == 8'h06) wel_q <= 1'b1;
            if (nb == 8'h04) wel_q <= 1'b0;
`endif
          end
          // Shifting the full 24 bits through leaves the AW LSBs in place
          ADDR: if (rise) begin
            addr_q <= {addr_q[AW-2:0], si_s[1]};
            if (done) begin
              cnt_q <= cnt_q + 2'd1;
              if (cnt_q == 2'd2) begin
`ifdef SPI_RESP_PROG_EN
                state_q <= prog_q ? DATA_IN : DATA_OUT;
                rd_q    <= !prog_q;
`else
                state_q <= DATA_OUT;
                rd_q    <= 1'b1;
`endif
              end
            end
          end
          DATA_OUT: begin
            if (done && src_q == SRC_MEM) begin
              addr_q <= addr_q + AW'(1);
              rd_q   <= 1'b1;
            end
            // bit_q is 0 only on the first fall of a byte: load, otherwise shift
            if (fall) begin
              so_q  <= bit_q == 3'd0 ? nxt[7] : out_q[6];
              out_q <= bit_q == 3'd0 ? nxt[6:0] : {out_q[5:0], 1'b0};
              if (bit_q == 3'd0 && src_q == SRC_ID && id_q != 2'd3) id_q <= id_q + 2'd1;
            end
          end
`ifdef SPI_RESP_PROG_EN
          DATA_IN: if (done && wel_q) begin
            wr_q    <= 1'b1;
            wdata_q <= nb;
          end
`endif
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: randomized SPI master with a transaction-level flash model and per-cycle output checks
module tb_spi_flash_responder;
  localparam int          AW  = 16;
  localparam logic [23:0] JID = 24'hEF4018;
`ifdef SPI_RESP_PROG_EN
  localparam bit PROG = 1'b1;
`else
  localparam bit PROG = 1'b0;
`endif
  logic clk = 0, reset = 1, spi_csb = 1, spi_clk = 0, spi_si = 0;
  logic spi_so, mem_rd, mem_wr, active;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00, mem_wdata;
  int checks = 0, errors = 0;
  int half = 5;
  logic [7:0] mem [0:65535];
  logic [7:0] mm [0:65535];
  logic wel_m = 1'b0;
  logic [15:0] exp_rd[$];
  logic [23:0] exp_wr[$];
  logic [7:0] tx_q[$], rx_q[$];
  logic h1 = 1'b1, h2 = 1'b1, h3 = 1'b1;

  spi_flash_responder #(.AW(AW), .JEDEC_ID(JID)) dut (
    .clk(clk), .reset(reset), .spi_csb(spi_csb), .spi_clk(spi_clk), .spi_si(spi_si),
    .spi_so(spi_so), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .active(active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Chip-select pin history in clk cycles
  always @(posedge clk or posedge reset)
    if (reset) begin
      h1 <= 1'b1;
      h2 <= 1'b1;
      h3 <= 1'b1;
    end else begin
      h1 <= spi_csb;
      h2 <= h1;
      h3 <= h2;
    end

  // Per-cycle compare: active tracks the pin 2 clk late; quiet outputs 3 clk after csb rise; memory strobes vs model
  always @(negedge clk) begin
    chk("active", active, !h2);
    if (h3) begin
      chk("so_idle", spi_so, 0);
      chk("rd_idle", mem_rd, 0);
      chk("wr_idle", mem_wr, 0);
    end
    if (mem_rd) begin
      if (exp_rd.size() == 0) chk("rd_extra", mem_rd, 0);
      else chk("rd_addr", mem_addr, exp_rd.pop_front());
    end
    if (mem_wr) begin
      if (exp_wr.size() == 0) chk("wr_extra", mem_wr, 0);
      else chk("wr_addr_data", {mem_addr, mem_wdata}, exp_wr.pop_front());
    end
  end

  function automatic logic [7:0] idb(input int i);
    return i == 1 ? JID[23:16] : i == 2 ? JID[15:8] : i == 3 ? JID[7:0] : 8'h00;
  endfunction

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_si = tx[i];
      repeat (half) @(negedge clk);
      rx[i] = spi_so;
      spi_clk = 1'b1;
      repeat (half) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  // One transaction: tx_q bytes, nd dummy 0x00 bytes, then part trailing bits of ptx
  task automatic run_txn(input int nd, input int part, input logic [7:0] ptx);
    logic [7:0] all[$], exp[$];
    logic [7:0] b, m, cmd;
    logic [15:0] a;
    int nf;
    all = tx_q;
    for (int i = 0; i < nd; i++) all.push_back(8'h00);
    nf = all.size();
    for (int i = 0; i <= nf; i++) exp.push_back(8'h00);
    cmd = nf > 0 ? all[0] : 8'h00;
    if (nf > 0) begin
      if (cmd == 8'h9F) for (int i = 1; i <= nf; i++) exp[i] = idb(i);
      if (cmd == 8'h05) for (int i = 1; i <= nf; i++) exp[i] = {6'b0, wel_m, 1'b0};
      if (cmd == 8'h03 && nf >= 4) begin
        a = {all[2], all[3]};
        for (int i = 4; i <= nf; i++) exp[i] = mm[a + 16'(i - 4)];
        for (int k = 0; k <= nf - 4; k++) exp_rd.push_back(a + 16'(k));
      end
      if (PROG) begin
        if (cmd == 8'h06) wel_m = 1'b1;
        if (cmd == 8'h04) wel_m = 1'b0;
        if (cmd == 8'h02 && nf >= 4 && wel_m) begin
          a = {all[2], all[3]};
          for (int i = 4; i < nf; i++) begin
            exp_wr.push_back({a, all[i]});
            mm[a] = all[i];
            a[7:0] = a[7:0] + 8'd1;
          end
        end
      end
    end
    rx_q.delete();
    spi_csb = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nf; i++) begin
      spi_bits(all[i], 8, b);
      rx_q.push_back(b);
      chk($sformatf("miso_byte%0d_cmd%0h", i, cmd), b, exp[i]);
    end
    if (part > 0) begin
      spi_bits(ptx, part, b);
      m = 8'hFF << (8 - part);
      chk("miso_partial", b & m, exp[nf] & m);
    end
    repeat (half) @(negedge clk);
    spi_csb = 1'b1;
    if (PROG && nf > 0 && cmd == 8'h02) wel_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("csb_rise_so", spi_so, 0);
    chk("csb_rise_active", active, 0);
    repeat (8) @(negedge clk);
    chk("rd_missing", exp_rd.size(), 0);
    chk("wr_missing", exp_wr.size(), 0);
  endtask

  int c, nd, part;
  logic [7:0] cmd, b;
  logic [15:0] a;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'(i);
      mm[i]  = 8'(i);
    end
    repeat (3) @(negedge clk);
    chk("rst_so", spi_so, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_wr", mem_wr, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_active", active, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    tx_q = '{8'h9F};
    run_txn(4, 0, 8'h00);
    chk("id_0", rx_q[1], 8'hEF);
    chk("id_1", rx_q[2], 8'h40);
    chk("id_2", rx_q[3], 8'h18);
    chk("id_3", rx_q[4], 8'h00);
    tx_q = '{8'h03, 8'h00, 8'h00, 8'h10};
    run_txn(4, 0, 8'h00);
    chk("rd10_0", rx_q[4], 8'h10);
    chk("rd10_3", rx_q[7], 8'h13);
    tx_q = '{8'h03, 8'h00, 8'hFF, 8'hFF};
    run_txn(2, 0, 8'h00);
    chk("wrap_ffff", rx_q[4], 8'hFF);
    chk("wrap_0000", rx_q[5], 8'h00);
    tx_q = '{8'h05};
    run_txn(1, 0, 8'h00);
    chk("status_init", rx_q[1], 8'h00);
    tx_q = '{8'h06};
    run_txn(0, 0, 8'h00);
    tx_q = '{8'h05};
    run_txn(1, 0, 8'h00);
    chk("status_wren", rx_q[1], PROG ? 8'h02 : 8'h00);
    tx_q = '{8'h04};
    run_txn(0, 0, 8'h00);
    tx_q = '{8'h05};
    run_txn(1, 0, 8'h00);
    chk("status_wrdi", rx_q[1], 8'h00);
    tx_q = '{8'h02, 8'h00, 8'h00, 8'h20, 8'hAA, 8'h55};
    run_txn(0, 0, 8'h00);
    chk("pp_nowel_20", mem[16'h0020], 8'h20);
    tx_q = '{8'h06};
    run_txn(0, 0, 8'h00);
    tx_q = '{8'h02, 8'h00, 8'h00, 8'h20, 8'hAA, 8'h55};
    run_txn(0, 0, 8'h00);
    chk("pp_20", mem[16'h0020], PROG ? 8'hAA : 8'h20);
    chk("pp_21", mem[16'h0021], PROG ? 8'h55 : 8'h21);
    tx_q = '{8'h05};
    run_txn(1, 0, 8'h00);
    chk("status_after_pp", rx_q[1], 8'h00);
    tx_q = '{8'h06};
    run_txn(0, 0, 8'h00);
    tx_q = '{8'h02, 8'h00, 8'h00, 8'h30};
    run_txn(0, 3, 8'hC3);
    chk("partial_no_write", mem[16'h0030], 8'h30);
    // Reset in the middle of a read data byte
    half = 5;
    exp_rd.push_back(16'h00F0);
    spi_csb = 1'b0;
    repeat (half) @(negedge clk);
    spi_bits(8'h03, 8, b);
    spi_bits(8'h00, 8, b);
    spi_bits(8'h00, 8, b);
    spi_bits(8'hF0, 8, b);
    spi_bits(8'h00, 3, b);
    chk("mid_bits", b, 8'hE0);
    repeat (half) @(negedge clk);
    chk("mid_so", spi_so, 1);
    chk("mid_addr", mem_addr, 16'h00F0);
    #2 reset = 1'b1;
    #1;
    chk("arst_so", spi_so, 0);
    chk("arst_rd", mem_rd, 0);
    chk("arst_wr", mem_wr, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_wdata", mem_wdata, 0);
    chk("arst_active", active, 0);
    wel_m = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    spi_csb = 1'b1;
    repeat (8) @(negedge clk);
    for (int t = 0; t < 30; t++) begin
      c = $urandom_range(0, 7);
      cmd = c == 0 ? 8'h9F : c == 1 ? 8'h05 : c == 2 ? 8'h06 : c == 3 ? 8'h04 :
            c <= 5 ? 8'h03 : c == 6 ? 8'h02 : 8'($urandom);
      half = $urandom_range(4, 6);
      tx_q.delete();
      tx_q.push_back(cmd);
      nd = 0;
      if (cmd == 8'h03 || cmd == 8'h02) begin
        a = $urandom_range(0, 2) == 0 ? 16'hFFFE :
            $urandom_range(0, 1) == 0 ? {8'($urandom), 8'hFD} : 16'($urandom);
        tx_q.push_back(8'($urandom));
        tx_q.push_back(a[15:8]);
        tx_q.push_back(a[7:0]);
      end
      if (cmd == 8'h02) repeat ($urandom_range(0, 4)) tx_q.push_back(8'($urandom));
      else nd = $urandom_range(0, 4);
      part = $urandom_range(0, 3) == 0 ? $urandom_range(1, 7) : 0;
      run_txn(nd, part, 8'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
